// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and control-bit bundle for the VGA output path.
package vga_timing_pkg;

  localparam int unsigned COLOR_W = 10;
  localparam int unsigned CNT_W   = 10;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  // Sync bits are "in sync" flags (active-high), polarity is applied at the pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } ctl_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
module vga_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster counters, coordinate/strobe outputs, and latency-matched sync/blank/RGB pins.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned HS_POL      = 0,
  parameter int unsigned VS_POL      = 0,
  parameter int unsigned PIX_LATENCY = 1
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [CNT_W-1:0]   oVGA_X,
  output logic [CNT_W-1:0]   oVGA_Y,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n,
  output logic               oVGA_SYNC_n,
  output logic               oFrame_start,
  output logic               oLine_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SS    = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SE    = H_SS + H_SYNC;
  localparam int unsigned V_SS    = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SE    = V_SS + V_SYNC;
  localparam logic        HS_ACT  = 1'(HS_POL);
  localparam logic        VS_ACT  = 1'(VS_POL);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $fatal(1, "vga_timing_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end
  if (PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "vga_timing_ctrl: PIX_LATENCY must be 1..4");
  end

  logic               run_q;
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0]   x_q, y_q;
  logic               fs_q, ls_q;
  logic               active_d;
  ctl_t               ctl_in, ctl_dly;
  logic               hs_q, vs_q, blank_n_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Counters hold at 0 for the first clock after reset so that h=0,v=0 is presented once.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (run_q) begin
      if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    active_d = (h_cnt_d < CNT_W'(H_ACTIVE)) && (v_cnt_d < CNT_W'(V_ACTIVE));
  end

  always_comb begin
    ctl_in.active = run_q && (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    ctl_in.hs     = run_q && (h_cnt_q >= CNT_W'(H_SS)) && (h_cnt_q < CNT_W'(H_SE));
    ctl_in.vs     = run_q && (v_cnt_q >= CNT_W'(V_SS)) && (v_cnt_q < CNT_W'(V_SE));
  end

  // X/Y and strobes load from next-state so they sit in the same cycle as the counters.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      run_q   <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      x_q     <= active_d ? h_cnt_d : '0;
      y_q     <= active_d ? v_cnt_d : '0;
      fs_q    <= (h_cnt_d == '0) && (v_cnt_d == '0);
      ls_q    <= (h_cnt_d == '0);
    end
  end

  vga_delay_line #(
    .DEPTH(PIX_LATENCY),
    .WIDTH($bits(ctl_t))
  ) u_ctl_dly (
    .clk_i  (iVGA_CLK),
    .rst_ni (iRST_n),
    .d_i    (ctl_in),
    .q_o    (ctl_dly)
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs_q      <= ~HS_ACT;
      vs_q      <= ~VS_ACT;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hs_q      <= ctl_dly.hs ? HS_ACT : ~HS_ACT;
      vs_q      <= ctl_dly.vs ? VS_ACT : ~VS_ACT;
      blank_n_q <= ctl_dly.active;
      r_q       <= ctl_dly.active ? iRed   : '0;
      g_q       <= ctl_dly.active ? iGreen : '0;
      b_q       <= ctl_dly.active ? iBlue  : '0;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oFrame_start = fs_q;
  assign oLine_start  = ls_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_n = blank_n_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full 640x480 timing at latency 1 and a shrunken raster at latency 3.
module tb_vga_timing_ctrl;

  logic clk;
  logic rst_n;

  logic [9:0] a_red, a_green, a_blue, a_x, a_y, a_r, a_g, a_b;
  logic       a_hs, a_vs, a_blank_n, a_sync_n, a_fs, a_ls;
  logic [9:0] b_red, b_green, b_blue, b_x, b_y, b_r, b_g, b_b;
  logic       b_hs, b_vs, b_blank_n, b_sync_n, b_fs, b_ls;
  logic [9:0] b_xp1, b_xp2, b_yp1, b_yp2;

  int checks   = 0;
  int failures = 0;
  int hs_low_a;

  vga_timing_ctrl #(.PIX_LATENCY(1)) dut_a (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .iRed(a_red), .iGreen(a_green), .iBlue(a_blue),
    .oVGA_X(a_x), .oVGA_Y(a_y), .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
    .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK_n(a_blank_n), .oVGA_SYNC_n(a_sync_n),
    .oFrame_start(a_fs), .oLine_start(a_ls)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HS_POL(1), .VS_POL(0), .PIX_LATENCY(3)
  ) dut_b (
    .iVGA_CLK(clk), .iRST_n(rst_n),
    .iRed(b_red), .iGreen(b_green), .iBlue(b_blue),
    .oVGA_X(b_x), .oVGA_Y(b_y), .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_n(b_blank_n), .oVGA_SYNC_n(b_sync_n),
    .oFrame_start(b_fs), .oLine_start(b_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Renderers: A echoes X one clock later, B returns X/Y three clocks later.
  always @(posedge clk) begin
    a_red   <= a_x;
    b_xp1   <= b_x;
    b_xp2   <= b_xp1;
    b_red   <= b_xp2;
    b_yp1   <= b_y;
    b_yp2   <= b_yp1;
    b_green <= b_yp2;
  end

  typedef struct {
    logic [9:0] x, y, r, g, b;
    logic       hs, vs, blank_n, fs, ls;
  } exp_t;

  typedef struct {
    int         k;
    logic [9:0] x, y, r;
    logic       hs, blank_n, ls, fs;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // k = posedges since reset release; coordinate for raster position k-1, pins for k-lat-2.
  function automatic exp_t model(int k, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, int lat,
                                 bit hpol, bit vpol, bit y_on_green);
    exp_t e;
    int ht, vt, p, q, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = k - 1;
    q  = k - lat - 2;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.x  = (h < ha && v < va) ? 10'(h) : 10'd0;
    e.y  = (h < ha && v < va) ? 10'(v) : 10'd0;
    e.fs = (h == 0 && v == 0);
    e.ls = (h == 0);
    e.hs = ~hpol;
    e.vs = ~vpol;
    e.blank_n = 1'b0;
    e.r = 10'd0;
    e.g = 10'd0;
    e.b = 10'd0;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      if (h >= ha + hf && h < ha + hf + hsw) e.hs = hpol;
      if (v >= va + vf && v < va + vf + vsw) e.vs = vpol;
      if (h < ha && v < va) begin
        e.blank_n = 1'b1;
        e.r = 10'(h);
        e.g = y_on_green ? 10'(v) : 10'h3FF;
        e.b = 10'h3FF;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h expected=%h", nm, k, act, exp);
    end
  endtask

  task automatic check_a(input int k);
    exp_t e;
    e = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, 1'b0);
    chk("a_x", k, a_x, e.x);
    chk("a_y", k, a_y, e.y);
    chk("a_r", k, a_r, e.r);
    chk("a_g", k, a_g, e.g);
    chk("a_b", k, a_b, e.b);
    chk("a_hs", k, 10'(a_hs), 10'(e.hs));
    chk("a_vs", k, 10'(a_vs), 10'(e.vs));
    chk("a_blank_n", k, 10'(a_blank_n), 10'(e.blank_n));
    chk("a_fs", k, 10'(a_fs), 10'(e.fs));
    chk("a_ls", k, 10'(a_ls), 10'(e.ls));
    chk("a_sync_n", k, 10'(a_sync_n), 10'd0);
  endtask

  task automatic check_b(input int k);
    exp_t e;
    e = model(k, 8, 2, 3, 2, 6, 2, 2, 3, 3, 1'b1, 1'b0, 1'b1);
    chk("b_x", k, b_x, e.x);
    chk("b_y", k, b_y, e.y);
    chk("b_r", k, b_r, e.r);
    chk("b_g", k, b_g, e.g);
    chk("b_b", k, b_b, e.b);
    chk("b_hs", k, 10'(b_hs), 10'(e.hs));
    chk("b_vs", k, 10'(b_vs), 10'(e.vs));
    chk("b_blank_n", k, 10'(b_blank_n), 10'(e.blank_n));
    chk("b_fs", k, 10'(b_fs), 10'(e.fs));
    chk("b_ls", k, 10'(b_ls), 10'(e.ls));
    chk("b_sync_n", k, 10'(b_sync_n), 10'd0);
  endtask

  task automatic check_reset(input int tag);
    chk("rst_a_x", tag, a_x, 10'd0);
    chk("rst_a_y", tag, a_y, 10'd0);
    chk("rst_a_r", tag, a_r, 10'd0);
    chk("rst_a_g", tag, a_g, 10'd0);
    chk("rst_a_hs", tag, 10'(a_hs), 10'd1);
    chk("rst_a_vs", tag, 10'(a_vs), 10'd1);
    chk("rst_a_blank_n", tag, 10'(a_blank_n), 10'd0);
    chk("rst_a_fs", tag, 10'(a_fs), 10'd0);
    chk("rst_a_ls", tag, 10'(a_ls), 10'd0);
    chk("rst_b_x", tag, b_x, 10'd0);
    chk("rst_b_r", tag, b_r, 10'd0);
    chk("rst_b_hs", tag, 10'(b_hs), 10'd0);
    chk("rst_b_vs", tag, 10'(b_vs), 10'd1);
    chk("rst_b_blank_n", tag, 10'(b_blank_n), 10'd0);
  endtask

  task automatic run(input int n, input bit use_tab, input int exp_hs_low);
    int vi, last_ls_a, last_ls_b, last_fs_b;
    vi = 0;
    last_ls_a = -1;
    last_ls_b = -1;
    last_fs_b = -1;
    hs_low_a  = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_a(k);
      check_b(k);
      if (!a_hs) hs_low_a++;
      if (use_tab && vi < NV && vecs[vi].k == k) begin
        chk("tab_x", k, a_x, vecs[vi].x);
        chk("tab_y", k, a_y, vecs[vi].y);
        chk("tab_r", k, a_r, vecs[vi].r);
        chk("tab_hs", k, 10'(a_hs), 10'(vecs[vi].hs));
        chk("tab_blank_n", k, 10'(a_blank_n), 10'(vecs[vi].blank_n));
        chk("tab_ls", k, 10'(a_ls), 10'(vecs[vi].ls));
        chk("tab_fs", k, 10'(a_fs), 10'(vecs[vi].fs));
        vi++;
      end
      if (a_ls) begin
        if (last_ls_a >= 0) chk("a_line_period", k, 10'(k - last_ls_a), 10'd800);
        last_ls_a = k;
      end
      if (b_ls) begin
        if (last_ls_b >= 0) chk("b_line_period", k, 10'(k - last_ls_b), 10'd15);
        last_ls_b = k;
      end
      if (b_fs) begin
        if (last_fs_b >= 0) chk("b_frame_period", k, 10'(k - last_fs_b), 10'd195);
        last_fs_b = k;
      end
    end
    chk("a_hs_low_cycles", n, 10'(hs_low_a), 10'(exp_hs_low));
    if (use_tab) chk("tab_applied", n, 10'(vi), 10'(NV));
  endtask

  initial begin
    rst_n   = 1'b0;
    a_green = 10'h3FF;
    a_blue  = 10'h3FF;
    b_blue  = 10'h3FF;

    //          k    x       y      r       hs    bl    ls    fs
    vecs[0]  = '{1,   10'd0,  10'd0, 10'd0,   1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2,   10'd1,  10'd0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3,   10'd2,  10'd0, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4,   10'd3,  10'd0, 10'd1,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{640, 10'd639, 10'd0, 10'd637, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{641, 10'd0,  10'd0, 10'd638, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{642, 10'd0,  10'd0, 10'd639, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{643, 10'd0,  10'd0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{658, 10'd0,  10'd0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{659, 10'd0,  10'd0, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{754, 10'd0,  10'd0, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{755, 10'd0,  10'd0, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{801, 10'd0,  10'd1, 10'd0,   1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{802, 10'd1,  10'd1, 10'd0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{803, 10'd2,  10'd1, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{804, 10'd3,  10'd1, 10'd1,   1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_reset(0);
    rst_n = 1'b1;
    run(2000, 1'b1, 192);

    // Asynchronous reset mid-frame (B is at h=4, v=3 here): outputs must clear at once.
    #1 rst_n = 1'b0;
    #1 check_reset(1);
    repeat (5) @(negedge clk);
    check_reset(2);
    rst_n = 1'b1;
    run(1000, 1'b0, 96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
